// File: rtl/stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_pkg
//  Description : Constants and elaboration-time helpers shared by the
//                stream_fifo block: clock-descriptor field positions and
//                parameter sanity checks.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_fifo_pkg;

    // Clock descriptor layout. All-zero means synchronous, active-high reset.
    localparam int c_clk_info_width         = 8;
    localparam int c_clk_info_async_bit     = 0;
    localparam int c_clk_info_active_low_bit = 1;

    function automatic bit clock_info_supported(input logic [c_clk_info_width-1:0] info);
        return !info[c_clk_info_async_bit] && !info[c_clk_info_active_low_bit];
    endfunction

    function automatic bit is_pow2_min2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_intf.sv
`default_nettype none
// ============================================================================
//  Module      : stream_intf
//  Description : Valid/ready streaming handshake with a W-bit payload.
//                Modport "in" is the receiving side (valid/payload in,
//                ready out); modport "out" is the sending side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_intf #(
    parameter int W = 1
);
    logic         valid;
    logic         ready;
    logic [W-1:0] payload;

    modport in  (input  valid, input  payload, output ready);
    modport out (output valid, output payload, input  ready);
endinterface
`default_nettype wire

// File: rtl/std_register.sv
`default_nettype none
// ============================================================================
//  Module      : std_register
//  Description : Enabled D register with synchronous active-high reset to a
//                parameterised reset vector.
//  Ports       : clk, rst, i_en (load enable), i_d (next value), o_q (state)
//  Revision    : 1.0 - initial release
// ============================================================================
module std_register #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/stream_fifo_storage.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_storage
//  Description : DEPTH x T memory, one synchronous write port with enable and
//                one asynchronous read port (maps onto distributed RAM).
//                Contents are not reset.
//  Ports       : clk, i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, o_rd_data
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo_storage
    import stream_fifo_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  T                  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output T                  o_rd_data
);
    if (!is_pow2_min2(DEPTH)) begin : g_bad_depth
        $error("stream_fifo_storage: DEPTH must be a power of two >= 2");
    end

    T r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo
//  Description : Multi-entry valid/ready FIFO with registered ready. Ready and
//                valid are decoded from the registered occupancy only, so no
//                combinational path exists from consumer ready to producer
//                ready. No fall-through: a pushed word is visible next cycle.
//  Ports       : clk        - clock
//                rst        - synchronous active-high reset
//                stream_in  - producer side (valid/payload in, ready out)
//                stream_out - consumer side (valid/payload out, ready in)
//                count      - registered occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter logic [c_clk_info_width-1:0] CLOCK_INFO = 'b0,
    parameter int                          DEPTH      = 4,
    parameter type                         T          = logic
) (
    input  logic                       clk,
    input  logic                       rst,
    stream_intf.in                     stream_in,
    stream_intf.out                    stream_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    typedef logic [c_ptr_w-1:0] ptr_t;
    typedef logic [c_cnt_w-1:0] count_t;

    localparam count_t c_full = count_t'(DEPTH);

    if (!clock_info_supported(CLOCK_INFO)) begin : g_bad_clock_info
        $error("stream_fifo: only synchronous active-high reset is supported");
    end
    if ($bits(T) != $bits(stream_in.payload) || $bits(T) != $bits(stream_out.payload)) begin : g_bad_width
        $error("stream_fifo: $bits(T) must match both interface payload widths");
    end

    ptr_t   r_wr_ptr;
    ptr_t   r_rd_ptr;
    count_t r_count;
    count_t w_count_nxt;
    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_push;
    logic   w_pop;
    T       w_wr_data;
    T       w_rd_data;

    // Both handshake outputs depend on the count flop alone.
    assign w_in_ready  = (r_count != c_full);
    assign w_out_valid = (r_count != '0);
    assign w_push      = stream_in.valid && w_in_ready;
    assign w_pop       = w_out_valid && stream_out.ready;

    // Only loaded when exactly one of push/pop happens, so the simultaneous
    // case leaves count untouched.
    assign w_count_nxt = w_push ? (r_count + count_t'(1)) : (r_count - count_t'(1));

    std_register #(.WIDTH(c_ptr_w), .RESET_VALUE('0)) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_push),
        .i_d  (r_wr_ptr + ptr_t'(1)),
        .o_q  (r_wr_ptr)
    );

    std_register #(.WIDTH(c_ptr_w), .RESET_VALUE('0)) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pop),
        .i_d  (r_rd_ptr + ptr_t'(1)),
        .o_q  (r_rd_ptr)
    );

    std_register #(.WIDTH(c_cnt_w), .RESET_VALUE('0)) u_count (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_push ^ w_pop),
        .i_d  (w_count_nxt),
        .o_q  (r_count)
    );

    assign w_wr_data = T'(stream_in.payload);

    stream_fifo_storage #(.DEPTH(DEPTH), .T(T)) u_storage (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign stream_in.ready    = w_in_ready;
    assign stream_out.valid   = w_out_valid;
    assign stream_out.payload = w_rd_data;
    assign count              = r_count;
endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_fifo
//  Description : Self-checking bench for stream_fifo (DEPTH=4, 8-bit payload)
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;
    localparam int c_depth = 4;

    logic       clk;
    logic       rst;
    logic [2:0] count;

    stream_intf #(.W(8)) in_if  ();
    stream_intf #(.W(8)) out_if ();

    stream_fifo #(
        .CLOCK_INFO ('b0),
        .DEPTH      (c_depth),
        .T          (logic [7:0])
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stream_in  (in_if),
        .stream_out (out_if),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] model_q[$];
    bit         last_push;
    bit         last_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output against the model's view of the queue.
    task automatic check_outputs(input string tag);
        check({tag, ".count"}, 32'(count), 32'(model_q.size()));
        check({tag, ".valid"}, 32'(out_if.valid), 32'(model_q.size() != 0));
        check({tag, ".ready"}, 32'(in_if.ready), 32'(model_q.size() != c_depth));
        if (model_q.size() != 0) begin
            check({tag, ".payload"}, 32'(out_if.payload), 32'(model_q[0]));
        end
    endtask

    // One clock: the model decides the transfers from current inputs and its
    // own occupancy, then the outputs are checked 1 time unit after the edge.
    task automatic step(input string tag);
        bit         push;
        bit         pop;
        logic [7:0] data;
        push = !rst && in_if.valid && (model_q.size() < c_depth);
        pop  = !rst && out_if.ready && (model_q.size() != 0);
        data = in_if.payload;
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
        end else begin
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(data);
        end
        last_push = push;
        last_pop  = pop;
        check_outputs(tag);
    endtask

    initial begin
        rst           = 1'b1;
        in_if.valid   = 1'b0;
        in_if.payload = 8'h00;
        out_if.ready  = 1'b0;

        // Reset state
        step("reset");
        step("reset");
        rst = 1'b0;
        step("idle");

        // Fill to full with consumer stalled
        for (int i = 0; i < 4; i++) begin
            in_if.valid   = 1'b1;
            in_if.payload = 8'(8'h11 * (i + 1));
            step("fill");
            check("fill.count_step", 32'(count), 32'(i + 1));
        end
        in_if.payload = 8'h55;
        step("fill.held");
        check("fill.fifth_held_off", 32'(count), 32'd4);
        check("fill.ready_low", 32'(in_if.ready), 32'd0);

        // Drain: 11,22,33,44 on consecutive cycles
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain.data", 32'(out_if.payload), 32'(8'h11 * (i + 1)));
            step("drain");
        end
        check("drain.empty_valid", 32'(out_if.valid), 32'd0);

        // Full with simultaneous pop
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_if.payload = 8'(8'hA0 + i);
            step("refill");
        end
        in_if.payload = 8'h55;
        out_if.ready  = 1'b1;
        step("full_pop");
        check("full_pop.no_push", 32'(count), 32'd3);
        check("full_pop.ready_back", 32'(in_if.ready), 32'd1);
        out_if.ready = 1'b0;
        step("full_pop.accept");
        check("full_pop.count4", 32'(count), 32'd4);
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) step("full_pop.drain");
        check("full_pop.tail_gone", 32'(model_q.size()), 32'(count));

        // Streaming 100 incrementing bytes
        in_if.valid   = 1'b1;
        in_if.payload = 8'h00;
        out_if.ready  = 1'b1;
        for (int i = 0; i < 101 && in_if.payload < 8'd100; i++) begin
            step("stream");
            if (i > 0) check("stream.count1", 32'(count), 32'd1);
            if (last_push) in_if.payload = in_if.payload + 8'd1;
        end
        in_if.valid = 1'b0;
        for (int i = 0; i < 2; i++) step("stream.drain");

        // Random stalls with wrap-around
        for (int i = 0; i < 300; i++) begin
            in_if.valid  = 1'($urandom_range(0, 1));
            out_if.ready = 1'($urandom_range(0, 2) != 0);
            if (last_push || i == 0) in_if.payload = 8'($urandom);
            step("random");
        end

        // Reset mid-operation at count=3
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        while (model_q.size() != 0) step("pre_rst.drain");
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_if.payload = 8'(8'hC0 + i);
            step("pre_rst.fill");
        end
        check("pre_rst.count3", 32'(count), 32'd3);
        in_if.valid = 1'b0;
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        check("mid_rst.valid0", 32'(out_if.valid), 32'd0);
        check("mid_rst.ready1", 32'(in_if.ready), 32'd1);
        in_if.valid   = 1'b1;
        in_if.payload = 8'hAA;
        step("post_rst.push");
        in_if.valid = 1'b0;
        check("post_rst.first_aa", 32'(out_if.payload), 32'h0AA);
        out_if.ready = 1'b1;
        step("post_rst.pop");
        check("post_rst.empty", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
